// File: rtl/seq_controle_if.sv
// Handshake bundle between seq_controle and its instruction memory, ALU, register file and data memory.
// The step input exists only when SEQ_SINGLE_STEP_EN is defined.
interface seq_controle_if #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic              alu_done;
  logic              mem_ack;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step;
`endif
  logic [PC_W-1:0]   pc;
  logic              fetch_req;
  logic              ir_load;
  logic              alu_start;
  logic              mem_req;
  logic              mem_we;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              reg_we;
  logic              busy;
  logic              halted;

  modport master (
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    input  start, instr_ready, opcode, alu_done, mem_ack,
    output pc, fetch_req, ir_load, alu_start, mem_req, mem_we,
    output clr_en, clr_addr, reg_we, busy, halted
  );

  modport slave (
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    output start, instr_ready, opcode, alu_done, mem_ack,
    input  pc, fetch_req, ir_load, alu_start, mem_req, mem_we,
    input  clr_en, clr_addr, reg_we, busy, halted
  );
endinterface

// File: rtl/seq_controle.sv
// Multicycle instruction sequencer: fetch, decode, execute, memory, writeback, memory clear and halt.
// Optional single-step pause after each instruction when SEQ_SINGLE_STEP_EN is defined.
module seq_controle #(
  parameter int PC_W      = 8,
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_controle_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, CLEAR, HALT
`ifdef SEQ_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

  typedef struct packed {
    logic fetch_req;
    logic alu_start;
    logic mem_req;
    logic mem_we;
    logic clr_en;
    logic reg_we;
    logic busy;
    logic halted;
  } outs_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_DEPTH - 1);
`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t DONE_ST = PAUSE;
`else
  localparam state_t DONE_ST = FETCH;
`endif

  state_t            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0] clr_addr, clr_addr_n;
  logic [2:0]        op_q, op_n;
  outs_t             outs;

  // Outputs are registered from the next state, so they track the state register exactly.
  function automatic outs_t state_outs(input state_t s, input logic [2:0] op, input logic entry);
    outs_t o;
    o      = '0;
    o.busy = (s != IDLE) && (s != HALT);
    case (s)
      FETCH:   o.fetch_req = 1'b1;
      EXEC:    o.alu_start = entry;
      MEM: begin
        o.mem_req = 1'b1;
        o.mem_we  = (op == 3'b111);
      end
      WB:      o.reg_we    = 1'b1;
      CLEAR:   o.clr_en    = 1'b1;
      HALT:    o.halted    = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    clr_addr_n = clr_addr;
    op_n       = op_q;
    case (state)
      IDLE:   if (bus.start) state_n = FETCH;
      FETCH:  if (bus.instr_ready) state_n = DECODE;
      DECODE: begin
        op_n = bus.opcode;
        case (bus.opcode)
          3'b100:         state_n = CLEAR;
          3'b101:         state_n = HALT;
          3'b110, 3'b111: state_n = MEM;
          default:        state_n = EXEC;
        endcase
      end
      // add/sub finish in one cycle; mul/div wait for the ALU
      EXEC: begin
        if ((op_q == 3'b000) || (op_q == 3'b001) || bus.alu_done) state_n = WB;
      end
      MEM: begin
        if (bus.mem_ack) begin
          if (op_q == 3'b111) begin
            pc_n    = pc + PC_W'(1);
            state_n = DONE_ST;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        pc_n    = pc + PC_W'(1);
        state_n = DONE_ST;
      end
      CLEAR: begin
        if (clr_addr == CLR_LAST) begin
          clr_addr_n = '0;
          pc_n       = pc + PC_W'(1);
          state_n    = DONE_ST;
        end else begin
          clr_addr_n = clr_addr + ADDR_W'(1);
        end
      end
      HALT: ;
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE:  if (bus.step) state_n = FETCH;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      clr_addr <= '0;
      op_q     <= '0;
      outs     <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      clr_addr <= clr_addr_n;
      op_q     <= op_n;
      outs     <= state_outs(state_n, op_n, state_n != state);
    end
  end

  assign bus.pc        = pc;
  assign bus.fetch_req = outs.fetch_req;
  assign bus.ir_load   = outs.fetch_req & bus.instr_ready;
  assign bus.alu_start = outs.alu_start;
  assign bus.mem_req   = outs.mem_req;
  assign bus.mem_we    = outs.mem_we;
  assign bus.clr_en    = outs.clr_en;
  assign bus.clr_addr  = clr_addr;
  assign bus.reg_we    = outs.reg_we;
  assign bus.busy      = outs.busy;
  assign bus.halted    = outs.halted;

endmodule

// File: tb/tb_seq_controle.sv
// Bench for seq_controle: directed instructions, randomized instruction stream, pc wrap, reset abort, halt.
module tb_seq_controle;
  localparam int PC_W      = 8;
  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr    = 0;
  int   exp_pc  = 0;

  seq_controle_if #(.PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();

  seq_controle #(.PC_W(PC_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.opcode      = 3'b000;
    bus.alu_done    = 1'b0;
    bus.mem_ack     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step        = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_pc",       bus.pc,        0);
    chk("rst_busy",     bus.busy,      0);
    chk("rst_fetch",    bus.fetch_req, 0);
    chk("rst_clr_en",   bus.clr_en,    0);
    chk("rst_clr_addr", bus.clr_addr,  0);
    chk("rst_halted",   bus.halted,    0);
    chk("rst_mem_req",  bus.mem_req,   0);
    chk("rst_reg_we",   bus.reg_we,    0);
    exp_pc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_run();
    bus.start       = 1'b1;
    bus.instr_ready = 1'($urandom);
    #1;
    chk("idle_busy",  bus.busy,      0);
    chk("idle_fetch", bus.fetch_req, 0);
    chk("idle_irld",  bus.ir_load,   0);
    tick();
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  // After any completed instruction: optional pause, then a fetch of the next pc.
  task automatic after_completion();
`ifdef SEQ_SINGLE_STEP_EN
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      bus.step = 1'b0;
      #1;
      chk("pause_busy",  bus.busy,      1);
      chk("pause_fetch", bus.fetch_req, 0);
      chk("pause_pc",    bus.pc,        32'(exp_pc));
      tick();
    end
    bus.step = 1'b1;
    #1;
    chk("pause_step_fetch", bus.fetch_req, 0);
    tick();
    bus.step = 1'b0;
`endif
    #1;
    chk("next_fetch", bus.fetch_req, 1);
    chk("next_pc",    bus.pc,        32'(exp_pc));
  endtask

  // Entered in the first FETCH cycle of an instruction.
  task automatic do_instr(input logic [2:0] op, input int rdly, input int adly, input int mdly);
    for (int i = 0; i < rdly; i++) begin
      bus.instr_ready = 1'b0;
      bus.alu_done    = 1'($urandom);
      bus.mem_ack     = 1'($urandom);
      #1;
      chk("fetch_wait_req", bus.fetch_req, 1);
      chk("fetch_wait_ld",  bus.ir_load,   0);
      tick();
    end
    bus.alu_done    = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b1;
    bus.opcode      = op;
    #1;
    chk("fetch_ir_load", bus.ir_load,   1);
    chk("fetch_req",     bus.fetch_req, 1);
    tick();
    bus.instr_ready = 1'($urandom);
    #1;
    chk("dec_busy",  bus.busy,    1);
    chk("dec_irld",  bus.ir_load, 0);
    chk("dec_pc",    bus.pc,      32'(exp_pc));
    tick();
    bus.opcode = 3'($urandom);
    case (op)
      3'b000, 3'b001: begin
        bus.alu_done = 1'($urandom);
        #1;
        chk("add_alu_start", bus.alu_start, 1);
        chk("add_reg_we",    bus.reg_we,    0);
        tick();
        bus.alu_done = 1'b0;
        #1;
        chk("add_wb_reg_we", bus.reg_we,    1);
        chk("add_wb_start",  bus.alu_start, 0);
        tick();
      end
      3'b010, 3'b011: begin
        for (int i = 0; i < adly; i++) begin
          bus.alu_done = 1'b0;
          #1;
          chk("mul_alu_start", bus.alu_start, 32'(i == 0));
          chk("mul_reg_we",    bus.reg_we,    0);
          tick();
        end
        bus.alu_done = 1'b1;
        #1;
        chk("mul_done_start", bus.alu_start, 32'(adly == 0));
        chk("mul_done_we",    bus.reg_we,    0);
        tick();
        bus.alu_done = 1'b0;
        #1;
        chk("mul_wb_reg_we", bus.reg_we, 1);
        tick();
      end
      3'b110, 3'b111: begin
        for (int i = 0; i < mdly; i++) begin
          bus.mem_ack = 1'b0;
          #1;
          chk("mem_req_wait", bus.mem_req, 1);
          chk("mem_we_wait",  bus.mem_we,  32'(op[0]));
          chk("mem_reg_we",   bus.reg_we,  0);
          tick();
        end
        bus.mem_ack = 1'b1;
        #1;
        chk("mem_req_ack", bus.mem_req, 1);
        chk("mem_we_ack",  bus.mem_we,  32'(op[0]));
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("mem_done_req", bus.mem_req, 0);
        chk("mem_wb_we",    bus.reg_we,  32'(op == 3'b110));
        if (op == 3'b110) tick();
      end
      3'b100: begin
        for (int a = 0; a < MEM_DEPTH; a++) begin
          bus.instr_ready = 1'($urandom);
          #1;
          chk("clr_en",      bus.clr_en,   1);
          chk("clr_addr",    bus.clr_addr, 32'(a));
          chk("clr_reg_we",  bus.reg_we,   0);
          chk("clr_mem_req", bus.mem_req,  0);
          chk("clr_irld",    bus.ir_load,  0);
          tick();
        end
        bus.instr_ready = 1'b0;
        #1;
        chk("clr_end_en",   bus.clr_en,   0);
        chk("clr_end_addr", bus.clr_addr, 0);
      end
      default: begin
        for (int i = 0; i < 6; i++) begin
          bus.start = 1'(i % 2);
          #1;
          chk("halt_halted", bus.halted,    1);
          chk("halt_busy",   bus.busy,      0);
          chk("halt_fetch",  bus.fetch_req, 0);
          tick();
        end
        bus.start = 1'b0;
      end
    endcase
    bus.instr_ready = 1'b0;
    if (op != 3'b101) begin
      exp_pc = (exp_pc + 1) % (1 << PC_W);
      after_completion();
    end
  endtask

  initial begin
    logic [2:0] op;
    int r;

    do_reset();
    start_run();
    do_instr(3'b000, 0, 0, 0);
    do_instr(3'b010, 1, 6, 0);
    do_instr(3'b110, 0, 0, 3);
    do_instr(3'b111, 2, 0, 3);
    do_instr(3'b100, 0, 0, 0);
    do_instr(3'b011, 0, 0, 0);
    do_instr(3'b111, 0, 0, 0);

    repeat (40) begin
      r  = $urandom_range(0, 6);
      op = 3'((r >= 5) ? r + 1 : r);
      do_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // pc wraps from 255 to 0
    do_reset();
    start_run();
    repeat (256) do_instr(3'b001, 0, 0, 0);
    chk("pc_wrap", bus.pc, 0);

    // asynchronous reset in the middle of a clear sweep
    do_reset();
    start_run();
    do_instr(3'b000, 0, 0, 0);
    do_instr(3'b000, 0, 0, 0);
    bus.instr_ready = 1'b1;
    bus.opcode      = 3'b100;
    tick();
    bus.instr_ready = 1'b0;
    tick();
    for (int a = 0; a < 7; a++) tick();
    #1;
    chk("abort_pre_addr", bus.clr_addr, 7);
    chk("abort_pre_en",   bus.clr_en,   1);
    chk("abort_pre_pc",   bus.pc,       2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_clr_en",   bus.clr_en,   0);
    chk("abort_clr_addr", bus.clr_addr, 0);
    chk("abort_pc",       bus.pc,       0);
    chk("abort_busy",     bus.busy,     0);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle_busy",  bus.busy,      0);
      chk("abort_idle_fetch", bus.fetch_req, 0);
      chk("abort_idle_clr",   bus.clr_en,    0);
    end

    // stop opcode parks the core
    start_run();
    do_instr(3'b000, 0, 0, 0);
    do_instr(3'b101, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b1;
      #1;
      chk("halt_hold",      bus.halted, 1);
      chk("halt_hold_busy", bus.busy,   0);
      chk("halt_hold_pc",   bus.pc,     1);
      tick();
    end
    bus.start = 1'b0;
    do_reset();
    chk("post_halt_reset", bus.halted, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule

// File: doc/seq_controle.md
Name: seq_controle

Overview:
- Multicycle instruction sequencer for the 3-bit-opcode datapath.
- It fetches each instruction and walks it through decode, execute, memory and writeback. It waits on the multicycle ALU and the data-memory handshake.
- It performs the memory-clear sweep address by address and parks the core on the stop opcode.
- It sits between the instruction memory, the opcode decoder and the ALU/register-file/data-memory enables.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- MEM_DEPTH, 16, number of data-memory words swept by a clear.
- ADDR_W, 4, width of clr_addr; MEM_DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from IDLE; ignored in every other state.
- instr_ready  in  1  instruction memory data valid for the current pc.
- opcode  in  3  opcode field of the instruction register; sampled in DECODE.
- alu_done  in  1  ALU result valid (mul/div completion).
- mem_ack  in  1  data memory access complete.
- pc  out  PC_W  program counter.
- fetch_req  out  1  instruction fetch request.
- ir_load  out  1  load instruction register.
- alu_start  out  1  one-cycle ALU launch pulse.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (valid with mem_req).
- clr_en  out  1  clear-write enable for the word at clr_addr.
- clr_addr  out  ADDR_W  address being cleared.
- reg_we  out  1  register-file write enable.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  stop opcode executed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, clr_addr=0.
  - All outputs 0 immediately.
  - Reset mid-operation aborts any state, including CLEAR and MEM, with no further enables.
- Output decoding:
  - Outputs are decoded from the state.
  - Exception: ir_load = (state==FETCH) & instr_ready.
- IDLE: all outputs 0; start=1 -> FETCH.
- FETCH:
  - fetch_req=1 until instr_ready=1.
  - In the instr_ready cycle, ir_load=1 and next state is DECODE.
  - No timeout.
- DECODE (1 cycle): opcode selects the next state.
  - 000/001/010/011 -> EXEC.
  - 100 -> CLEAR.
  - 110/111 -> MEM.
  - 101 -> HALT.
  - The opcode is latched internally; later opcode changes are ignored.
- EXEC:
  - alu_start=1 on the entry cycle only.
  - add/sub (000/001): -> WB after exactly 1 cycle; alu_done is ignored.
  - div/mul (010/011): stay until alu_done=1, which is accepted in the entry cycle too; then -> WB.
- MEM:
  - mem_req=1, and mem_we=1 iff opcode 111; held stable until mem_ack=1.
  - On mem_ack: read (110) -> WB; write (111) -> pc+1, then FETCH.
- WB (1 cycle): reg_we=1; pc<=pc+1; -> FETCH.
- CLEAR:
  - clr_en=1 every cycle; clr_addr steps 0,1,...,MEM_DEPTH-1, one per cycle (MEM_DEPTH cycles total).
  - After the last address: clr_addr<=0, pc+1, -> FETCH.
- HALT: halted=1, busy=0. Exited only by reset; start is ignored.
- Spurious inputs: instr_ready, alu_done and mem_ack outside their waiting state are ignored.
- PC wrap: PC_W'hFF+1 -> 0 with no flag.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - Every instruction completion (exit of WB, write MEM, or CLEAR) enters PAUSE instead of FETCH, with pc already incremented.
  - PAUSE: all enables 0, busy=1; step=1 -> FETCH.
  - HALT is not affected.
- When undefined: no step port, no PAUSE state; behaviour exactly as above.

Test Plan:
- Add instruction:
  - Stimulus: reset, start=1 at cycle 0, instr_ready=1 at cycle 1, opcode=000.
  - Required response: ir_load at cycle 1, alu_start at cycle 3, reg_we at cycle 4, pc=1 and fetch_req=1 at cycle 5.
- Divide:
  - Stimulus: opcode=010, alu_done asserted 6 cycles after alu_start.
  - Required response: state held in EXEC, reg_we exactly one cycle after alu_done, pc incremented once.
- Memory read then write:
  - Stimulus: 110 then 111, mem_ack delayed 3 cycles each.
  - Required response: mem_req held 4 cycles each; mem_we=0 then 1; reg_we only for the read; pc=2 after both.
- Clear:
  - Stimulus: opcode=100 with MEM_DEPTH=16.
  - Required response: clr_en high 16 consecutive cycles, clr_addr 0..15, then FETCH with pc+1; no reg_we/mem_req.
- Stop and reset abort:
  - Stimulus (stop): opcode=101.
  - Required response (stop): halted=1 and busy=0 permanently; start pulses ignored.
  - Stimulus (abort): rst_n=0 asserted asynchronously at clr_addr=7.
  - Required response (abort): clr_en=0, pc=0, state IDLE without a clock edge.
- PC wrap with single step (SEQ_SINGLE_STEP_EN defined):
  - Stimulus: pc preloaded to 255 by running 255 adds.
  - Required response: next pc=0; core waits in PAUSE until step=1.
